// File: rtl/alu_pkg.sv
// Shared width and opcode encoding for the registered ALU.
package alu_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Request/response bus between the ALU, its driver and its monitors.
interface alu_if;
  import alu_pkg::*;

  logic             valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] result;
  logic             carry;

  modport master (
    output valid, a, b, opcode,
    input  result, carry
  );

  modport slave (
    input  valid, a, b, opcode,
    output result, carry
  );

  modport monitor (
    input valid, a, b, opcode, result, carry
  );

endinterface

// File: rtl/alu_comb.sv
// Combinational datapath: next result and carry/borrow/shift-out for one request.
module alu_comb
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_opcode,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  logic [WIDTH:0] w_wide;
  alu_op_e        w_op;

  assign w_op = alu_op_e'(i_opcode);

  always_comb begin
    w_wide   = '0;
    o_result = '0;
    o_carry  = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_wide   = {1'b0, i_a} + {1'b0, i_b};
        o_result = w_wide[WIDTH-1:0];
        o_carry  = w_wide[WIDTH];
      end
      // Extended subtraction wraps into bit WIDTH exactly when a < b.
      OP_SUB: begin
        w_wide   = {1'b0, i_a} - {1'b0, i_b};
        o_result = w_wide[WIDTH-1:0];
        o_carry  = w_wide[WIDTH];
      end
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_NOT: o_result = ~i_a;
      OP_SHL: begin
        o_result = {i_a[WIDTH-2:0], 1'b0};
        o_carry  = i_a[WIDTH-1];
      end
      OP_SHR: begin
        o_result = {1'b0, i_a[WIDTH-1:1]};
        o_carry  = i_a[0];
      end
      default: begin
        o_result = '0;
        o_carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_modport.sv
// Registered ALU: valid-gated output flops with synchronous active-low reset.
module alu_modport
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;

  alu_comb u_alu_comb (
    .i_a      (bus.a),
    .i_b      (bus.b),
    .i_opcode (bus.opcode),
    .o_result (w_result),
    .o_carry  (w_carry)
  );

  // Reset wins over a coincident request, which is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_carry  <= 1'b0;
    end else if (bus.valid) begin
      r_result <= w_result;
      r_carry  <= w_carry;
    end
  end

  assign bus.result = r_result;
  assign bus.carry  = r_carry;

endmodule

// File: tb/tb_alu_modport.sv
// Directed-vector bench for alu_modport; expected {carry,result} values are hand-computed.
module tb_alu_modport;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  alu_if bus ();

  alu_modport dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got carry=%0b result=0x%02h, expected carry=%0b result=0x%02h",
               tag, got[8], got[7:0], exp[8], exp[7:0]);
    end else begin
      $display("ok   %s: carry=%0b result=0x%02h", tag, got[8], got[7:0]);
    end
  endtask

  // Drive one cycle of stimulus, let one edge pass, then check the registered outputs.
  task automatic step(input string tag, input logic rst, input logic v, input alu_op_e op,
                      input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
    rst_n      = rst;
    bus.valid  = v;
    bus.opcode = op;
    bus.a      = a;
    bus.b      = b;
    @(posedge clk);
    #1;
    chk(tag, {bus.carry, bus.result}, exp);
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    rst_n      = 1'b0;
    bus.valid  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.opcode = '0;
    @(posedge clk);
    #1;

    step("reset0", 1'b0, 1'b1, OP_ADD, 8'h12, 8'h34, 9'h000);
    step("reset1", 1'b0, 1'b1, OP_ADD, 8'h12, 8'h34, 9'h000);

    step("add_ovf",  1'b1, 1'b1, OP_ADD, 8'hFF, 8'h01, 9'h100);
    step("add_norm", 1'b1, 1'b1, OP_ADD, 8'h12, 8'h34, 9'h046);
    step("sub_brw",  1'b1, 1'b1, OP_SUB, 8'h05, 8'h0A, 9'h1FB);
    step("sub_eq",   1'b1, 1'b1, OP_SUB, 8'h80, 8'h80, 9'h000);

    step("and", 1'b1, 1'b1, OP_AND, 8'hA5, 8'h3C, 9'h024);
    step("or",  1'b1, 1'b1, OP_OR,  8'hA5, 8'h3C, 9'h0BD);
    step("xor", 1'b1, 1'b1, OP_XOR, 8'hA5, 8'h3C, 9'h099);
    step("not", 1'b1, 1'b1, OP_NOT, 8'hA5, 8'h3C, 9'h05A);
    step("shl", 1'b1, 1'b1, OP_SHL, 8'hA5, 8'h3C, 9'h14A);
    step("shr", 1'b1, 1'b1, OP_SHR, 8'hA5, 8'h3C, 9'h152);

    step("b2b_0", 1'b1, 1'b1, OP_ADD, 8'h10, 8'h20, 9'h030);
    step("b2b_1", 1'b1, 1'b1, OP_SUB, 8'h00, 8'h01, 9'h1FF);
    step("b2b_2", 1'b1, 1'b1, OP_SHL, 8'h80, 8'h00, 9'h100);
    step("hold0", 1'b1, 1'b0, OP_ADD, 8'hFF, 8'hFF, 9'h100);
    step("hold1", 1'b1, 1'b0, OP_NOT, 8'h00, 8'h00, 9'h100);
    step("hold2", 1'b1, 1'b0, OP_XOR, 8'h0F, 8'h33, 9'h100);

    step("mid_pre",  1'b1, 1'b1, OP_ADD, 8'h01, 8'h02, 9'h003);
    step("mid_rst",  1'b0, 1'b1, OP_ADD, 8'h40, 8'h40, 9'h000);
    step("mid_post", 1'b1, 1'b1, OP_OR,  8'h0F, 8'hF0, 9'h0FF);
    step("mid_hold", 1'b1, 1'b0, OP_ADD, 8'h40, 8'h40, 9'h0FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
